// File: rtl/iob_accum_pkg.sv
// Shared constants for the accumulator bank: overflow modes and channel-index width.
package iob_accum_pkg;

    localparam int ACC_WRAP = 0;
    localparam int ACC_SAT  = 1;

    // A single-channel bank still needs a 1-bit channel port.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iob_accum_alu.sv
// Sign-extend-and-add datapath with signed overflow detect and optional clamp.
module iob_accum_alu
    import iob_accum_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40,
    parameter int SAT    = ACC_WRAP
) (
    input  logic [ACC_W-1:0]  i_base,
    input  logic [DATA_W-1:0] i_x,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic [ACC_W-1:0] w_xe;
    logic [ACC_W-1:0] w_raw;

    assign w_xe  = ACC_W'($signed(i_x));
    assign w_raw = i_base + w_xe;
    assign o_ovf = (i_base[ACC_W-1] == w_xe[ACC_W-1]) && (w_raw[ACC_W-1] != i_base[ACC_W-1]);

    // On overflow both operands share a sign, so the base sign picks the rail.
    always_comb begin
        o_sum = w_raw;
        if (SAT == ACC_SAT && o_ovf)
            o_sum = i_base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end

endmodule

// File: rtl/iob_accum_bank.sv
// N_CH-channel signed accumulator bank with sticky overflow, clears, done pulse and read-back.
module iob_accum_bank
    import iob_accum_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40,
    parameter int N_CH   = 4,
    parameter int SAT    = ACC_WRAP,
    localparam int CH_W  = ch_w(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CH_W-1:0]   ch,
    input  logic [DATA_W-1:0] x,
    input  logic              clr,
    input  logic              clr_all,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [ACC_W-1:0]  y,
    output logic              done,
    output logic [CH_W-1:0]   done_ch,
    output logic [ACC_W-1:0]  done_y,
    output logic [N_CH-1:0]   ovf
);

    logic [N_CH-1:0][ACC_W-1:0] r_acc;
    logic [N_CH-1:0]            r_ovf;
    logic [ACC_W-1:0]           r_y;
    logic                       r_done;
    logic [CH_W-1:0]            r_done_ch;
    logic [ACC_W-1:0]           r_done_y;

    logic              w_ch_ok, w_rd_ok;
    logic [CH_W-1:0]   w_idx, w_rd_idx;
    logic [ACC_W-1:0]  w_base, w_sum;
    logic              w_add_ovf;

    // Out-of-range indices (non power-of-two N_CH) are folded to 0 and gated.
    assign w_ch_ok  = int'(ch) < N_CH;
    assign w_rd_ok  = int'(rd_ch) < N_CH;
    assign w_idx    = w_ch_ok ? ch : '0;
    assign w_rd_idx = w_rd_ok ? rd_ch : '0;
    assign w_base   = clr ? '0 : r_acc[w_idx];

    iob_accum_alu #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SAT(SAT)) u_alu (
        .i_base (w_base),
        .i_x    (x),
        .o_sum  (w_sum),
        .o_ovf  (w_add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_ovf     <= '0;
            r_y       <= '0;
            r_done    <= 1'b0;
            r_done_ch <= '0;
            r_done_y  <= '0;
        end else begin
            r_done <= 1'b0;
            r_y    <= w_rd_ok ? r_acc[w_rd_idx] : '0;
            if (clr_all) begin
                r_acc <= '0;
                r_ovf <= '0;
            end else if (w_ch_ok) begin
                if (en) begin
                    r_acc[w_idx] <= w_sum;
                    r_ovf[w_idx] <= (r_ovf[w_idx] & ~clr) | w_add_ovf;
                    r_done       <= 1'b1;
                    r_done_ch    <= w_idx;
                    r_done_y     <= w_sum;
                end else if (clr) begin
                    r_acc[w_idx] <= '0;
                    r_ovf[w_idx] <= 1'b0;
                end
            end
        end
    end

    assign y       = r_y;
    assign done    = r_done;
    assign done_ch = r_done_ch;
    assign done_y  = r_done_y;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_iob_accum_bank.sv
// Bench: wrap and saturate banks (8-bit samples, 10-bit acc, 3 channels) driven in lockstep against an integer model.
module tb_iob_accum_bank;
    import iob_accum_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, clr = 1'b0, clr_all = 1'b0;
    logic [1:0] ch = '0, rd_ch = '0;
    logic [7:0] x = '0;

    logic [9:0] y0, y1, dy0, dy1;
    logic       d0, d1;
    logic [1:0] dc0, dc1;
    logic [2:0] o0, o1;

    iob_accum_bank #(.DATA_W(8), .ACC_W(10), .N_CH(3), .SAT(ACC_WRAP)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .ch(ch), .x(x), .clr(clr), .clr_all(clr_all),
        .rd_ch(rd_ch), .y(y0), .done(d0), .done_ch(dc0), .done_y(dy0), .ovf(o0));

    iob_accum_bank #(.DATA_W(8), .ACC_W(10), .N_CH(3), .SAT(ACC_SAT)) u_sat (
        .clk(clk), .rst(rst), .en(en), .ch(ch), .x(x), .clr(clr), .clr_all(clr_all),
        .rd_ch(rd_ch), .y(y1), .done(d1), .done_ch(dc1), .done_y(dy1), .ovf(o1));

    always #5 clk = ~clk;

    // Model: index 0 = wrap bank, 1 = saturating bank; values held as plain integers.
    int vectors = 0;
    int miscompares = 0;
    int macc [2][3];
    bit movf [2][3];
    int exp_y [2];
    int exp_dy [2];
    bit exp_done;
    int exp_dch;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 3; c++) begin
                macc[m][c] = 0;
                movf[m][c] = 1'b0;
            end
            exp_y[m] = 0;
            exp_dy[m] = 0;
        end
        exp_done = 1'b0;
        exp_dch = 0;
    endtask

    task automatic model_edge();
        int s;
        exp_done = 1'b0;
        for (int m = 0; m < 2; m++) begin
            exp_y[m] = (rd_ch < 3) ? macc[m][rd_ch] : 0;
            if (clr_all) begin
                for (int c = 0; c < 3; c++) begin
                    macc[m][c] = 0;
                    movf[m][c] = 1'b0;
                end
            end else if (ch < 3) begin
                if (en) begin
                    if (clr) begin
                        macc[m][ch] = 0;
                        movf[m][ch] = 1'b0;
                    end
                    s = macc[m][ch] + int'($signed(x));
                    if (s > 511 || s < -512) begin
                        movf[m][ch] = 1'b1;
                        if (m == 0) s = (s > 511) ? s - 1024 : s + 1024;
                        else        s = (s > 511) ? 511 : -512;
                    end
                    macc[m][ch] = s;
                    exp_done = 1'b1;
                    exp_dch = int'(ch);
                    exp_dy[m] = s;
                end else if (clr) begin
                    macc[m][ch] = 0;
                    movf[m][ch] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".y_wrap"}, y0, 10'(exp_y[0]));
        chk({tag, ".y_sat"}, y1, 10'(exp_y[1]));
        chk({tag, ".done_wrap"}, {9'd0, d0}, {9'd0, exp_done});
        chk({tag, ".done_sat"}, {9'd0, d1}, {9'd0, exp_done});
        chk({tag, ".ovf_wrap"}, {7'd0, o0}, {7'd0, movf[0][2], movf[0][1], movf[0][0]});
        chk({tag, ".ovf_sat"}, {7'd0, o1}, {7'd0, movf[1][2], movf[1][1], movf[1][0]});
        if (exp_done) begin
            chk({tag, ".done_ch_wrap"}, {8'd0, dc0}, 10'(exp_dch));
            chk({tag, ".done_ch_sat"}, {8'd0, dc1}, 10'(exp_dch));
            chk({tag, ".done_y_wrap"}, dy0, 10'(exp_dy[0]));
            chk({tag, ".done_y_sat"}, dy1, 10'(exp_dy[1]));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".y_wrap"}, y0, 10'd0);
        chk({tag, ".y_sat"}, y1, 10'd0);
        chk({tag, ".done_wrap"}, {9'd0, d0}, 10'd0);
        chk({tag, ".done_sat"}, {9'd0, d1}, 10'd0);
        chk({tag, ".done_ch_wrap"}, {8'd0, dc0}, 10'd0);
        chk({tag, ".done_y_wrap"}, dy0, 10'd0);
        chk({tag, ".done_y_sat"}, dy1, 10'd0);
        chk({tag, ".ovf_wrap"}, {7'd0, o0}, 10'd0);
        chk({tag, ".ovf_sat"}, {7'd0, o1}, 10'd0);
    endtask

    // Called at posedge+1: drives inputs, advances model, checks after the next edge.
    task automatic step(input string tag, input logic e, input logic [1:0] c, input logic [7:0] xv,
                        input logic cl, input logic ca, input logic [1:0] rc);
        en = e; ch = c; x = xv; clr = cl; clr_all = ca; rd_ch = rc;
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #2 check_zero("reset");
        @(posedge clk);
        #3 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step("single", 1'b1, 2'd0, 8'd1, 1'b0, 1'b0, 2'd0);
            step("single_idle", 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0);
        end

        for (int c = 0; c < 3; c++) step("clr_pre", 1'b0, 2'(c), 8'd0, 1'b1, 1'b0, 2'd0);
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 3; c++)
                step("rr", 1'b1, 2'(c), 8'(c + 1), 1'b0, 1'b0, 2'(c));
        for (int rc = 0; rc < 4; rc++) step("sweep", 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'(rc));

        step("pos_clr", 1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) step("pos_fill", 1'b1, 2'd0, 8'd127, 1'b0, 1'b0, 2'd0);
        step("pos_max", 1'b1, 2'd0, 8'd3, 1'b0, 1'b0, 2'd0);
        step("pos_ovf", 1'b1, 2'd0, 8'd1, 1'b0, 1'b0, 2'd0);
        step("pos_back", 1'b1, 2'd0, 8'hFF, 1'b0, 1'b0, 2'd0);
        step("pos_read", 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0);

        step("neg_clr", 1'b0, 2'd2, 8'd0, 1'b1, 1'b0, 2'd2);
        for (int i = 0; i < 4; i++) step("neg_fill", 1'b1, 2'd2, 8'h80, 1'b0, 1'b0, 2'd2);
        step("neg_ovf", 1'b1, 2'd2, 8'hFF, 1'b0, 1'b0, 2'd2);
        step("neg_read", 1'b0, 2'd2, 8'd0, 1'b0, 1'b0, 2'd2);

        step("c2_clr", 1'b0, 2'd2, 8'd0, 1'b1, 1'b0, 2'd2);
        for (int i = 0; i < 8; i++) step("c2_fill", 1'b1, 2'd2, 8'd5, 1'b0, 1'b0, 2'd2);
        step("clr_en", 1'b1, 2'd2, 8'd5, 1'b1, 1'b0, 2'd2);
        step("clr_en_rd", 1'b0, 2'd2, 8'd0, 1'b0, 1'b0, 2'd2);
        step("clrall_en", 1'b1, 2'd1, 8'd7, 1'b0, 1'b1, 2'd1);
        step("clrall_rd", 1'b0, 2'd1, 8'd0, 1'b0, 1'b0, 2'd1);
        step("c1_add", 1'b1, 2'd1, 8'd9, 1'b0, 1'b0, 2'd1);
        step("clr_only", 1'b0, 2'd1, 8'd0, 1'b1, 1'b0, 2'd1);
        step("clr_only_rd", 1'b0, 2'd1, 8'd0, 1'b0, 1'b0, 2'd1);

        step("bad_ch_pre", 1'b1, 2'd0, 8'd4, 1'b0, 1'b0, 2'd0);
        step("bad_ch_en", 1'b1, 2'd3, 8'd9, 1'b0, 1'b0, 2'd0);
        step("bad_ch_clr", 1'b0, 2'd3, 8'd0, 1'b1, 1'b0, 2'd3);
        step("bad_ch_rd", 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0);

        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                en = 1'b1; ch = 2'd0; x = 8'd1; clr = 1'b0; clr_all = 1'b0;
                #2 rst = 1'b1;
                model_reset();
                #1 check_zero("midrst");
                @(posedge clk);
                #1 check_zero("midrst_hold");
                #2 rst = 1'b0;
                step("after_rst", 1'b1, 2'd0, 8'd1, 1'b0, 1'b0, 2'd0);
                step("after_rst_rd", 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0);
            end
            step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0),
                 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
